// File: rtl/controle_multiciclo_if.sv
// Bundle of the control inputs and the status/phase-enable outputs exchanged
// between the multi-cycle sequencer (slave) and the datapath/top level (master).
interface controle_multiciclo_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned CNT_W   = 32
);
  logic [INSTR_W-1:0] instrucao;
  logic               mem_ready;
  logic               halt_req;
  logic               step_en;
  logic               step_go;
  logic               restart;

  logic [3:0]         estado;
  logic               en_if;
  logic               en_id;
  logic               en_ex;
  logic               en_mem;
  logic               en_wb;
  logic               en_pc;
  logic               fim;
  logic               erro;
  logic [CNT_W-1:0]   ciclos;
  logic [CNT_W-1:0]   instrs;

  modport master (
    output instrucao, mem_ready, halt_req, step_en, step_go, restart,
    input  estado, en_if, en_id, en_ex, en_mem, en_wb, en_pc,
           fim, erro, ciclos, instrs
  );

  modport slave (
    input  instrucao, mem_ready, halt_req, step_en, step_go, restart,
    output estado, en_if, en_id, en_ex, en_mem, en_wb, en_pc,
           fim, erro, ciclos, instrs
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multi-cycle RISC-V sequencer: IF/ID/EX/MEM/WB/SUMPC with wait states,
// memory-ready stall timeout, halt, single-step, restart and cycle/instr counters.
module controle_multiciclo #(
  parameter int unsigned INSTR_W      = 32,
  parameter int unsigned WAIT_EX      = 2,
  parameter int unsigned WAIT_WB      = 2,
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned HALT_ON_ZERO = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  controle_multiciclo_if.slave  ctl
);

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_EX    = 4'd2,
    S_MEM   = 4'd3,
    S_WB    = 4'd4,
    S_EXW   = 4'd5,
    S_WBW   = 4'd6,
    S_SUMPC = 4'd8,
    S_FIM   = 4'd9,
    S_STEP  = 4'd10
  } estado_t;

  // Counters load "cycles - 1" so the wait state lasts exactly WAIT_x cycles.
  localparam logic [3:0]         WAIT_EX_LAST = 4'(WAIT_EX - 1);
  localparam logic [3:0]         WAIT_WB_LAST = 4'(WAIT_WB - 1);
  localparam logic [7:0]         STALL_LAST   = 8'(MEM_TIMEOUT - 1);
  localparam logic [INSTR_W-1:0] INSTR_FIM    = '0;
  localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);

  estado_t          state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [7:0]       stall_q, stall_d;
  logic             erro_q, erro_d;
  logic [CNT_W-1:0] ciclos_q, ciclos_d;
  logic [CNT_W-1:0] instrs_q, instrs_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IF;
      wait_q   <= '0;
      stall_q  <= '0;
      erro_q   <= 1'b0;
      ciclos_q <= '0;
      instrs_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      stall_q  <= stall_d;
      erro_q   <= erro_d;
      ciclos_q <= ciclos_d;
      instrs_q <= instrs_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    stall_d  = stall_q;
    erro_d   = erro_q;
    ciclos_d = ciclos_q;
    instrs_d = instrs_q;

    if (state_q != S_FIM && ciclos_q != '1) begin
      ciclos_d = ciclos_q + CNT_ONE;
    end

    unique case (state_q)
      S_IF: begin
        state_d = S_ID;
      end

      S_ID: begin
        if (ctl.halt_req || (HALT_ON_ZERO != 0 && ctl.instrucao == INSTR_FIM)) begin
          state_d = S_FIM;
        end else begin
          state_d = S_EX;
        end
      end

      S_EX: begin
        if (WAIT_EX > 0) begin
          state_d = S_EXW;
          wait_d  = WAIT_EX_LAST;
        end else begin
          state_d = S_MEM;
          stall_d = '0;
        end
      end

      S_EXW: begin
        if (wait_q == '0) begin
          state_d = S_MEM;
          stall_d = '0;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      // stall_q counts MEM cycles already spent without mem_ready.
      S_MEM: begin
        if (ctl.mem_ready) begin
          state_d = S_WB;
        end else if (MEM_TIMEOUT > 0 && stall_q == STALL_LAST) begin
          state_d = S_FIM;
          erro_d  = 1'b1;
        end else if (stall_q != '1) begin
          stall_d = stall_q + 8'd1;
        end
      end

      S_WB: begin
        if (WAIT_WB > 0) begin
          state_d = S_WBW;
          wait_d  = WAIT_WB_LAST;
        end else begin
          state_d = S_SUMPC;
        end
      end

      S_WBW: begin
        if (wait_q == '0) begin
          state_d = S_SUMPC;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      S_SUMPC: begin
        if (instrs_q != '1) begin
          instrs_d = instrs_q + CNT_ONE;
        end
        state_d = ctl.step_en ? S_STEP : S_IF;
      end

      S_STEP: begin
        if (ctl.halt_req) begin
          state_d = S_FIM;
        end else if (ctl.step_go) begin
          state_d = S_IF;
        end
      end

      S_FIM: begin
        if (ctl.restart) begin
          state_d  = S_IF;
          erro_d   = 1'b0;
          ciclos_d = '0;
          instrs_d = '0;
        end
      end

      default: begin
        state_d = S_IF;
      end
    endcase
  end

  assign ctl.estado = state_q;
  assign ctl.en_if  = (state_q == S_IF);
  assign ctl.en_id  = (state_q == S_ID);
  assign ctl.en_ex  = (state_q == S_EX);
  assign ctl.en_mem = (state_q == S_MEM);
  assign ctl.en_wb  = (state_q == S_WB);
  assign ctl.en_pc  = (state_q == S_SUMPC);
  assign ctl.fim    = (state_q == S_FIM);
  assign ctl.erro   = erro_q;
  assign ctl.ciclos = ciclos_q;
  assign ctl.instrs = instrs_q;

endmodule
